fp_round_unit: RTL

// Consumer end of the FPU result path: takes an unrounded single-precision result plus guard/round/sticky

---
 rtl/fp_round_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_round_unit.sv
// Single-precision rounding back end: captures an unrounded FU result with G/R/S bits,
// applies the rounding mode over a 4-state FSM and presents the float plus fflags for writeback.
module fp_round_unit #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clk_en_i,
  input  logic                      valid_i,
  input  logic [EXP_W+MANT_W:0]     to_round_unit_i,
  input  logic [2:0]                grs_i,
  input  logic [2:0]                round_mode_i,
  input  logic                      invalid_op_i,
  input  logic                      overflow_i,
  input  logic                      underflow_i,
  input  logic                      div_zero_i,
  output logic                      ready_o,
  output logic [EXP_W+MANT_W:0]     result_o,
  output logic [4:0]                fflags_o,
  output logic                      illegal_rm_o,
  output logic                      valid_o
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_NORM, S_VALID} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [2:0]        grs;
    logic [2:0]        rm;
    logic              nv;
    logic              of;
    logic              uf;
    logic              dz;
  } req_t;

  state_t              state_q, state_d;
  req_t                req_q;
  logic                inc;
  logic [MANT_W+1:0]   sum_d, sum_q;
  logic                carry;
  logic [EXP_W-1:0]    exp_n;
  logic [MANT_W-1:0]   mant_n;
  logic [W-1:0]        inf_res, max_res, ovf_res, res_d;
  logic [4:0]          flags_d;
  logic                illeg_d;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      state_q <= S_IDLE;
    else if (clk_en_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = S_ROUND;
      S_ROUND: state_d = S_NORM;
      S_NORM:  state_d = S_VALID;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_IDLE);
    valid_o = (state_q == S_VALID);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      req_q <= '0;
    else if (clk_en_i && state_q == S_IDLE && valid_i)
      req_q <= {to_round_unit_i, grs_i, round_mode_i, invalid_op_i, overflow_i, underflow_i, div_zero_i};
  end

  // Round-up decision and significand add, implicit one included
  always_comb begin
    inc = 1'b0;
    case (req_q.rm)
      3'd0:    inc = req_q.grs[2] & (req_q.grs[1] | req_q.grs[0] | req_q.mant[0]);
      3'd2:    inc = req_q.sign & (|req_q.grs);
      3'd3:    inc = ~req_q.sign & (|req_q.grs);
      3'd4:    inc = req_q.grs[2];
      default: inc = 1'b0;
    endcase
    sum_d = {1'b0, 1'b1, req_q.mant} + {{(MANT_W+1){1'b0}}, inc};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                            sum_q <= '0;
    else if (clk_en_i && state_q == S_ROUND) sum_q <= sum_d;
  end

  // Renormalise on carry-out; the shifted-out bits are all zero in that case
  always_comb begin
    carry   = sum_q[MANT_W+1];
    exp_n   = req_q.exp + {{(EXP_W-1){1'b0}}, carry};
    mant_n  = carry ? sum_q[MANT_W:1] : sum_q[MANT_W-1:0];
    inf_res = {req_q.sign, EXP_ONES, {MANT_W{1'b0}}};
    max_res = {req_q.sign, EXP_MAXF, {MANT_W{1'b1}}};
    case (req_q.rm)
      3'd1:    ovf_res = max_res;
      3'd2:    ovf_res = req_q.sign ? inf_res : max_res;
      3'd3:    ovf_res = req_q.sign ? max_res : inf_res;
      default: ovf_res = inf_res;
    endcase

    res_d   = {req_q.sign, exp_n, mant_n};
    flags_d = {4'b0000, |req_q.grs};
    illeg_d = 1'b0;
    if (req_q.rm > 3'd4) begin
      res_d = QNAN; flags_d = 5'b10000; illeg_d = 1'b1;
    end else if (req_q.nv) begin
      res_d = QNAN; flags_d = 5'b10000;
    end else if (req_q.of) begin
      res_d = ovf_res; flags_d = 5'b00101;
    end else if (req_q.uf) begin
      res_d = '0; flags_d = 5'b00011;
    end else if (req_q.dz) begin
      res_d = {req_q.sign, req_q.exp, req_q.mant}; flags_d = 5'b01000;
    end else if (req_q.exp == EXP_ONES) begin
      res_d   = (|req_q.mant) ? QNAN : {req_q.sign, req_q.exp, req_q.mant};
      flags_d = '0;
    end else if (req_q.exp == '0) begin
      // no denormal output: flush to signed zero, true zero passes unchanged
      res_d   = {req_q.sign, {(W-1){1'b0}}};
      flags_d = (|req_q.mant) ? 5'b00011 : 5'b00000;
    end else if (exp_n == EXP_ONES) begin
      res_d = ovf_res; flags_d = 5'b00101;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o     <= '0;
      fflags_o     <= '0;
      illegal_rm_o <= 1'b0;
    end else if (clk_en_i && state_q == S_NORM) begin
      result_o     <= res_d;
      fflags_o     <= flags_d;
      illegal_rm_o <= illeg_d;
    end
  end

endmodule
